mac_operand_feeder: RTL and testbench

- Upstream operand sequencer for the floating-point MAC datapath.
- Holds a TAPS-deep coefficient bank and a sample delay line.
- For each accepted input sample, streams TAPS (signal, coeff) IEEE-754 single-precision pairs into the MAC datapath, one per cycle, with LD_signal/LD_coeff strobes.
- Replaces the fixed-pattern controller when the MAC runs as an FIR tap engine.

---
 rtl/mac_operand_feeder.sv | 141 ++++++++++++++
 tb/tb_mac_operand_feeder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_operand_feeder.sv
// FIR operand sequencer: coefficient bank plus sample delay line; each accepted sample is
// streamed as TAPS (signal, coeff) pairs with LD strobes. Optional macro: SKIP_ZERO_COEFF_EN.
module mac_operand_feeder #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAPS       = 8,
  parameter int unsigned ADDR_W     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  coeff_wr_en,
  input  logic [ADDR_W-1:0]     coeff_wr_addr,
  input  logic [DATA_WIDTH-1:0] coeff_wr_data,
  output logic                  coeff_wr_err,
  input  logic                  flush,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample_data,
  output logic                  sample_ready,
  output logic [DATA_WIDTH-1:0] signal,
  output logic [DATA_WIDTH-1:0] coeff,
  output logic                  LD_signal,
  output logic                  LD_coeff,
  output logic [ADDR_W-1:0]     tap_idx,
  output logic                  frame_start,
  output logic                  frame_done,
  output logic                  busy
);
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] TAPS_C = CNT_W'(TAPS);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(TAPS - 1);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [DATA_WIDTH-1:0] line [TAPS];
  logic [DATA_WIDTH-1:0] bank [TAPS];

  logic                  accept, wr_ok;
  logic [ADDR_W-1:0]     tap_sel, idx_n;
  logic [DATA_WIDTH-1:0] sig_n, coef_n;
  logic                  ld_n, start_n, done_n, busy_n, err_n;

  assign sample_ready = (state == IDLE);
  assign accept       = sample_valid && sample_ready;
  assign wr_ok        = coeff_wr_en && (state == IDLE) && ({1'b0, coeff_wr_addr} < TAPS_C);
  assign tap_sel      = cnt[ADDR_W-1:0];

  // Tap 0 is launched on the accept edge; cnt then names the next tap to present.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sig_n   = '0;
    coef_n  = '0;
    idx_n   = '0;
    ld_n    = 1'b0;
    start_n = 1'b0;
    done_n  = 1'b0;
    busy_n  = 1'b0;
    err_n   = coeff_wr_en && !wr_ok;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = ISSUE;
          cnt_n   = CNT_W'(1);
          sig_n   = sample_data;
          coef_n  = (wr_ok && coeff_wr_addr == '0) ? coeff_wr_data : bank[0];
          ld_n    = 1'b1;
          start_n = 1'b1;
          busy_n  = 1'b1;
        end
      end
      ISSUE: begin
        if (cnt == TAPS_C) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n  = cnt + CNT_W'(1);
          sig_n  = line[tap_sel];
          coef_n = bank[tap_sel];
          idx_n  = tap_sel;
          ld_n   = 1'b1;
          done_n = (cnt == LAST_C);
          busy_n = 1'b1;
        end
      end
    endcase
`ifdef SKIP_ZERO_COEFF_EN
    if (coef_n[30:0] == 31'd0) ld_n = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      signal       <= '0;
      coeff        <= '0;
      tap_idx      <= '0;
      LD_signal    <= 1'b0;
      LD_coeff     <= 1'b0;
      frame_start  <= 1'b0;
      frame_done   <= 1'b0;
      busy         <= 1'b0;
      coeff_wr_err <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      signal       <= sig_n;
      coeff        <= coef_n;
      tap_idx      <= idx_n;
      LD_signal    <= ld_n;
      LD_coeff     <= ld_n;
      frame_start  <= start_n;
      frame_done   <= done_n;
      busy         <= busy_n;
      coeff_wr_err <= err_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(TAPS); k++) bank[k] <= '0;
    end else if (wr_ok) begin
      bank[coeff_wr_addr] <= coeff_wr_data;
    end
  end

  // Delay line moves only in IDLE; flush clears before the new sample lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(TAPS); k++) line[k] <= '0;
    end else if (state == IDLE) begin
      if (accept) begin
        for (int k = 1; k < int'(TAPS); k++) line[k] <= flush ? '0 : line[k-1];
        line[0] <= sample_data;
      end else if (flush) begin
        for (int k = 0; k < int'(TAPS); k++) line[k] <= '0;
      end
    end
  end
endmodule

// File: tb/tb_mac_operand_feeder.sv
// Scoreboard bench for mac_operand_feeder: random and directed stimulus against a
// frame-level model of the coefficient bank and delay line.
module tb_mac_operand_feeder;
  localparam int unsigned DW   = 32;
  localparam int unsigned TAPS = 8;
  localparam int unsigned AW   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          coeff_wr_en = 1'b0, flush = 1'b0, sample_valid = 1'b0;
  logic [AW-1:0] coeff_wr_addr = '0;
  logic [DW-1:0] coeff_wr_data = '0, sample_data = '0;
  logic          coeff_wr_err, sample_ready, LD_signal, LD_coeff, frame_start, frame_done, busy;
  logic [DW-1:0] signal, coeff;
  logic [AW-1:0] tap_idx;

  mac_operand_feeder #(.DATA_WIDTH(DW), .TAPS(TAPS), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .coeff_wr_en(coeff_wr_en), .coeff_wr_addr(coeff_wr_addr), .coeff_wr_data(coeff_wr_data),
    .coeff_wr_err(coeff_wr_err), .flush(flush),
    .sample_valid(sample_valid), .sample_data(sample_data), .sample_ready(sample_ready),
    .signal(signal), .coeff(coeff), .LD_signal(LD_signal), .LD_coeff(LD_coeff),
    .tap_idx(tap_idx), .frame_start(frame_start), .frame_done(frame_done), .busy(busy)
  );

  // Six-tap instance: only used to exercise out-of-range coefficient addresses.
  logic          w6_en = 1'b0;
  logic [AW-1:0] w6_addr = '0;
  logic [DW-1:0] w6_data = '0;
  logic          err6, ready6, ld_s6, ld_c6, start6, done6, busy6;
  logic [DW-1:0] signal6, coeff6;
  logic [AW-1:0] idx6;

  mac_operand_feeder #(.DATA_WIDTH(DW), .TAPS(6), .ADDR_W(AW)) dut6 (
    .clk(clk), .rst(rst),
    .coeff_wr_en(w6_en), .coeff_wr_addr(w6_addr), .coeff_wr_data(w6_data),
    .coeff_wr_err(err6), .flush(1'b0),
    .sample_valid(1'b0), .sample_data(32'h0), .sample_ready(ready6),
    .signal(signal6), .coeff(coeff6), .LD_signal(ld_s6), .LD_coeff(ld_c6),
    .tap_idx(idx6), .frame_start(start6), .frame_done(done6), .busy(busy6)
  );

  typedef struct {
    int           at;
    logic [DW-1:0] sig;
    logic [DW-1:0] cof;
    logic [AW-1:0] idx;
    logic         st;
    logic         dn;
    logic         ld;
  } exp_t;

  exp_t          q[$];
  exp_t          mx;
  logic [DW-1:0] m_bank[TAPS];
  logic [DW-1:0] m_line[TAPS];
  bit            exp_err[int];
  int            free_edge = 0;
  int            e = 0;
  int            checks = 0;
  int            failures = 0;
  bit            mon_en = 1'b0;

  always @(posedge clk) e <= e + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%h expected=%h", name, e, act, exp);
    end
  endtask

  // Monitor: every cycle either a scheduled tap pair or quiet idle outputs.
  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() != 0 && q[0].at == e) begin
        mx = q.pop_front();
        chk("busy", 32'(busy), 32'd1);
        chk("signal", signal, mx.sig);
        chk("coeff", coeff, mx.cof);
        chk("tap_idx", 32'(tap_idx), 32'(mx.idx));
        chk("frame_start", 32'(frame_start), 32'(mx.st));
        chk("frame_done", 32'(frame_done), 32'(mx.dn));
        chk("LD_signal", 32'(LD_signal), 32'(mx.ld));
        chk("LD_coeff", 32'(LD_coeff), 32'(mx.ld));
      end else begin
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_ld", 32'({LD_signal, LD_coeff, frame_start, frame_done}), 32'd0);
        chk("idle_signal", signal, 32'd0);
        chk("idle_coeff", coeff, 32'd0);
      end
      chk("coeff_wr_err", 32'(coeff_wr_err), 32'(exp_err.exists(e)));
    end
  end

  // One cycle of stimulus; the model state afterwards reflects the coming edge.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit w, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input bit f, output bit acc);
    int E;
    bit idle;
    exp_t x;
    @(negedge clk);
    E    = e + 1;
    idle = (E >= free_edge);
    acc  = idle && v;
    chk("sample_ready", 32'(sample_ready), 32'(idle));
    sample_valid  = v;
    sample_data   = d;
    coeff_wr_en   = w;
    coeff_wr_addr = a;
    coeff_wr_data = wd;
    flush         = f;
    if (w) begin
      if (idle && int'(a) < int'(TAPS)) m_bank[a] = wd;
      else exp_err[E] = 1'b1;
    end
    if (idle) begin
      if (f) for (int k = 0; k < int'(TAPS); k++) m_line[k] = '0;
      if (v) begin
        for (int k = int'(TAPS) - 1; k > 0; k--) m_line[k] = m_line[k-1];
        m_line[0] = d;
        for (int i = 0; i < int'(TAPS); i++) begin
          x.at  = E + i;
          x.sig = m_line[i];
          x.cof = m_bank[i];
          x.idx = AW'(i);
          x.st  = (i == 0);
          x.dn  = (i == int'(TAPS) - 1);
`ifdef SKIP_ZERO_COEFF_EN
          x.ld  = (m_bank[i][30:0] != 31'd0);
`else
          x.ld  = 1'b1;
`endif
          q.push_back(x);
        end
        free_edge = E + int'(TAPS) + 1;
      end
    end
  endtask

  task automatic idle_step();
    bit acc;
    step(1'b0, '0, 1'b0, '0, '0, 1'b0, acc);
  endtask

  // Present a sample with valid held until the feeder takes it.
  task automatic push_sample(input logic [DW-1:0] d, input bit f);
    bit acc;
    acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) step(1'b1, d, 1'b0, '0, '0, f, acc);
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL push_timeout edge=%0d got=not-accepted expected=accepted", e);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_err.delete();
    for (int k = 0; k < int'(TAPS); k++) begin
      m_bank[k] = '0;
      m_line[k] = '0;
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    case ($urandom_range(3))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog edge=%0d got=timeout expected=finish", e);
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    model_reset();
    repeat (10) @(negedge clk);
    chk("rst_ready", 32'(sample_ready), 32'd1);
    chk("rst_ld", 32'({LD_signal, LD_coeff}), 32'd0);
    chk("rst_signal", signal, 32'd0);
    chk("rst_coeff", coeff, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    free_edge = e + 1;
    mon_en = 1'b1;

    // Single frame with known operands
    step(1'b0, '0, 1'b1, 3'd0, 32'h40B2_0419, 1'b0, acc);
    for (int i = 1; i < int'(TAPS); i++) step(1'b0, '0, 1'b1, AW'(i), 32'h3F80_0000, 1'b0, acc);
    step(1'b1, 32'h4136_0000, 1'b0, '0, '0, 1'b0, acc);
    idle_step();
    chk("kat_sig0", signal, 32'h4136_0000);
    chk("kat_coef0", coeff, 32'h40B2_0419);
    chk("kat_start", 32'(frame_start), 32'd1);
    for (int i = 1; i < int'(TAPS); i++) begin
      idle_step();
      chk("kat_sig", signal, 32'h0);
      chk("kat_coef", coeff, 32'h3F80_0000);
    end
    chk("kat_done", 32'(frame_done), 32'd1);
    idle_step();
    chk("kat_ready", 32'(sample_ready), 32'd1);

    // Delay line ordering, valid held back-to-back after a flush
    step(1'b0, '0, 1'b0, '0, '0, 1'b1, acc);
    push_sample(32'h3F80_0000, 1'b0);
    push_sample(32'h4000_0000, 1'b0);
    push_sample(32'h4040_0000, 1'b0);
    idle_step();
    chk("dl_tap0", signal, 32'h4040_0000);
    idle_step();
    chk("dl_tap1", signal, 32'h4000_0000);
    idle_step();
    chk("dl_tap2", signal, 32'h3F80_0000);
    idle_step();
    chk("dl_tap3", signal, 32'h0);

    // Write while busy is dropped; write to addr 7 in idle lands
    step(1'b0, '0, 1'b1, 3'd0, 32'hDEAD_BEEF, 1'b0, acc);
    repeat (6) idle_step();
    step(1'b0, '0, 1'b1, 3'd7, 32'h4120_0000, 1'b0, acc);
    push_sample(32'h3FC0_0000, 1'b0);
    repeat (TAPS + 1) idle_step();

    // Out-of-range address on the six-tap instance
    @(negedge clk);
    w6_en = 1'b1; w6_addr = 3'd7; w6_data = 32'h1234_5678;
    @(negedge clk);
    w6_addr = 3'd5;
    chk("t6_err_addr7", 32'(err6), 32'd1);
    @(negedge clk);
    w6_en = 1'b0;
    chk("t6_err_addr5", 32'(err6), 32'd0);
    chk("t6_ready", 32'(ready6), 32'd1);
    chk("t6_quiet", 32'({busy6, ld_s6, ld_c6, start6, done6, idx6}), 32'd0);
    chk("t6_operands", signal6 | coeff6, 32'd0);

    // Negative zero coefficient on tap 2
    step(1'b0, '0, 1'b1, 3'd2, 32'h8000_0000, 1'b0, acc);
    push_sample(32'h4080_0000, 1'b0);
    repeat (3) idle_step();
`ifdef SKIP_ZERO_COEFF_EN
    chk("skip_tap2_ld", 32'(LD_signal), 32'd0);
`else
    chk("skip_tap2_ld", 32'(LD_signal), 32'd1);
`endif
    repeat (5) idle_step();
    chk("skip_done", 32'(frame_done), 32'd1);

    // Reset mid-frame at tap 3
    push_sample(32'h4110_0000, 1'b0);
    repeat (4) idle_step();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_ld", 32'({LD_signal, LD_coeff}), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(sample_ready), 32'd1);
    model_reset();
    sample_valid = 1'b0; coeff_wr_en = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    free_edge = e + 1;
    push_sample(32'h4150_0000, 1'b0);
    repeat (TAPS + 1) idle_step();

    // Random traffic
    for (int n = 0; n < 900; n++) begin
      step($urandom_range(1) == 1, rnd_data(), $urandom_range(3) == 0, AW'($urandom),
           rnd_data(), $urandom_range(15) == 0, acc);
    end
    repeat (TAPS + 3) idle_step();
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
